gf180mcu_fd_sc_mcu9t5v0__tsbus_drvseq: RTL and testbench

// Sequencer that drives the EN/I pins of NAGENT banks of W invz tri-state inverters sharing one bus.

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__tsbus_drvseq_pkg.sv | 14 +
 rtl/gf180mcu_fd_sc_mcu9t5v0__tsbus_rr_arb.sv | 32 +++
 rtl/gf180mcu_fd_sc_mcu9t5v0__tsbus_drvseq.sv | 140 ++++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__tsbus_drvseq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__tsbus_drvseq_pkg.sv
// Shared definitions for the tri-state bus drive sequencer.
// Holds the FSM encoding and the value an undriven invz bank sees on I.
package gf180mcu_fd_sc_mcu9t5v0__tsbus_drvseq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TURN  = 2'd1,
    ST_DRIVE = 2'd2
  } state_e;

  // Inverted idle level: an invz bank with EN low parks its I pins at one.
  localparam logic I_IDLE_BIT = 1'b1;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__tsbus_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr_i, with wrap.
module gf180mcu_fd_sc_mcu9t5v0__tsbus_rr_arb #(
  parameter int NAGENT = 4,
  parameter int IW     = $clog2(NAGENT)
) (
  input  logic [NAGENT-1:0] req_i,
  input  logic [IW-1:0]     ptr_i,
  output logic [NAGENT-1:0] gnt_o,
  output logic [IW-1:0]     idx_o,
  output logic              any_o
);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    sum   = '0;
    cand  = '0;
    any_o = |req_i;
    // Walk offsets high-to-low so the nearest requester to ptr_i is written last.
    for (int k = NAGENT - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_i} + (IW+1)'(k);
      if (sum >= (IW+1)'(NAGENT)) sum = sum - (IW+1)'(NAGENT);
      cand = sum[IW-1:0];
      if (req_i[cand]) idx_o = cand;
    end
    if (any_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__tsbus_drvseq.sv
// Drives EN/I of NAGENT invz banks on a shared bus: round-robin ownership,
// break-before-make dead time, and pre-inverted data so bus ZN equals DIN.
module gf180mcu_fd_sc_mcu9t5v0__tsbus_drvseq
  import gf180mcu_fd_sc_mcu9t5v0__tsbus_drvseq_pkg::*;
#(
  parameter int NAGENT   = 4,
  parameter int W        = 8,
  parameter int TURN     = 2,
  parameter int MAXBURST = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NAGENT-1:0]   REQ,
  input  logic [NAGENT*W-1:0] DIN,
  output logic [NAGENT-1:0]   GNT,
  output logic [NAGENT-1:0]   EN,
  output logic [NAGENT*W-1:0] I,
  output logic                BUSY
);

  localparam int IW = $clog2(NAGENT);
  localparam int BW = $clog2(MAXBURST + 1);
  localparam int TW = (TURN > 1) ? $clog2(TURN) : 1;

  state_e              state_q, state_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic [BW-1:0]       bcnt_q, bcnt_d;
  logic [NAGENT-1:0]   en_q, en_d;
  logic [NAGENT*W-1:0] i_q, i_d;
  logic                busy_q, busy_d;

  logic [NAGENT-1:0]   arb_gnt;
  logic [IW-1:0]       arb_idx;
  logic                arb_any;
  logic [NAGENT-1:0]   own_oh;
  logic                others_req;

  gf180mcu_fd_sc_mcu9t5v0__tsbus_rr_arb #(
    .NAGENT (NAGENT),
    .IW     (IW)
  ) u_arb (
    .req_i (REQ),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign own_oh     = NAGENT'(1) << owner_q;
  assign others_req = |(REQ & ~own_oh);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    en_d    = '0;
    i_d     = {(NAGENT*W){I_IDLE_BIT}};
    busy_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          owner_d = arb_idx;
          tcnt_d  = TW'(TURN - 1);
          state_d = ST_TURN;
        end
      end
      ST_TURN: begin
        // Owner withdrawing during turnaround aborts without ever enabling its bank.
        if (!REQ[owner_q]) begin
          state_d = ST_IDLE;
        end else if (tcnt_q == '0) begin
          state_d = ST_DRIVE;
          bcnt_d  = BW'(1);
        end else begin
          tcnt_d = tcnt_q - 1'b1;
        end
      end
      ST_DRIVE: begin
        if (!REQ[owner_q] || (bcnt_q == BW'(MAXBURST) && others_req)) begin
          state_d = ST_IDLE;
          bcnt_d  = '0;
          ptr_d   = (owner_q == IW'(NAGENT - 1)) ? '0 : owner_q + 1'b1;
        end else if (bcnt_q == BW'(MAXBURST)) begin
          bcnt_d = BW'(1);
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    if (state_d == ST_DRIVE) begin
      en_d[owner_d]        = 1'b1;
      i_d[owner_d*W +: W]  = ~DIN[owner_d*W +: W];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      en_q    <= '0;
      i_q     <= {(NAGENT*W){I_IDLE_BIT}};
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      en_q    <= en_d;
      i_q     <= i_d;
      busy_q  <= busy_d;
    end
  end

  assign EN   = en_q;
  assign GNT  = en_q;
  assign I    = i_q;
  assign BUSY = busy_q;

`ifndef FUNCTIONAL
  specify
    (CLK *> EN)   = (0, 0);
    (CLK *> GNT)  = (0, 0);
    (CLK *> I)    = (0, 0);
    (CLK *> BUSY) = (0, 0);
  endspecify
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__tsbus_drvseq.sv
// Bench for the tri-state bus drive sequencer: directed table, corner sequences,
// and random traffic against a transaction-level reference model.
module tb_gf180mcu_fd_sc_mcu9t5v0__tsbus_drvseq;

  localparam int N = 4, W = 8, TURN = 2, MB = 4;

  logic           CLK = 1'b0;
  logic           RST;
  logic [N-1:0]   REQ;
  logic [N*W-1:0] DIN;
  logic [N-1:0]   GNT, EN;
  logic [N*W-1:0] I;
  logic           BUSY;

  gf180mcu_fd_sc_mcu9t5v0__tsbus_drvseq #(
    .NAGENT(N), .W(W), .TURN(TURN), .MAXBURST(MB)
  ) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .DIN(DIN),
    .GNT(GNT), .EN(EN), .I(I), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Reference model: who owns the bus, how many edges until it may drive,
  // how long it has held, and where the next search starts.
  int             m_owner = -1;
  int             m_wait = 0;
  int             m_held = 0;
  int             m_ptr = 0;
  bit             m_granted = 0;
  logic [N*W-1:0] m_i = '1;

  // Bus activity monitor
  logic [N-1:0] en_prev = '0;
  int  low_run = 0, high_run = 0;
  bit  had_fall = 0;
  int  q_own[$], q_high[$], q_gap[$];

  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    logic [31:0]  din;
    logic [N-1:0] en;
    logic         busy;
    logic [31:0]  i;
  } vec_t;
  vec_t tbl[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit others;
    if (RST) begin
      m_owner = -1; m_granted = 0; m_ptr = 0; m_i = '1;
    end else if (m_owner < 0) begin
      if (REQ != '0) begin
        for (int k = 0; k < N; k++) begin
          if (REQ[(m_ptr + k) % N]) begin
            m_owner = (m_ptr + k) % N;
            break;
          end
        end
        m_wait = TURN;
      end
    end else if (!m_granted) begin
      if (!REQ[m_owner]) m_owner = -1;
      else begin
        m_wait--;
        if (m_wait == 0) begin
          m_granted = 1; m_held = 1;
          m_i = '1; m_i[m_owner*W +: W] = ~DIN[m_owner*W +: W];
        end
      end
    end else begin
      others = (REQ & ~(N'(1) << m_owner)) != '0;
      if (!REQ[m_owner] || (m_held == MB && others)) begin
        m_ptr = (m_owner + 1) % N;
        m_owner = -1; m_granted = 0; m_i = '1;
      end else begin
        m_held = (m_held == MB) ? 1 : m_held + 1;
        m_i[m_owner*W +: W] = ~DIN[m_owner*W +: W];
      end
    end
  endtask

  task automatic step();
    logic [N-1:0] m_en;
    int idx;
    @(posedge CLK);
    model_edge();
    #1;
    m_en = m_granted ? (N'(1) << m_owner) : '0;
    check("model_en", EN, m_en);
    check("model_i", I, m_i);
    check("model_busy", BUSY, m_owner >= 0);
    check("en_eq_gnt", EN == GNT, 1);
    check("onehot0", $onehot0(EN), 1);
    if (EN != '0) begin
      if (en_prev == '0) begin
        idx = -1;
        for (int k = 0; k < N; k++) if (EN[k]) idx = k;
        if (had_fall) check("deadtime", low_run >= TURN + 1, 1);
        q_own.push_back(idx);
        q_gap.push_back(low_run);
        high_run = 0;
      end
      high_run++;
    end else begin
      if (en_prev != '0) begin
        q_high.push_back(high_run);
        had_fall = 1;
        low_run = 0;
      end
      low_run++;
    end
    en_prev = EN;
  endtask

  task automatic do_reset();
    RST = 1'b1; REQ = '0; DIN = '0;
    step(); step();
    RST = 1'b0;
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  initial begin
    int hi_cnt;
    tbl[0]  = '{0, 4'b0001, 32'h0000_00A5, 4'b0000, 1, 32'hFFFF_FFFF};
    tbl[1]  = '{0, 4'b0001, 32'h0000_00A5, 4'b0000, 1, 32'hFFFF_FFFF};
    tbl[2]  = '{0, 4'b0001, 32'h0000_00A5, 4'b0001, 1, 32'hFFFF_FF5A};
    tbl[3]  = '{0, 4'b0001, 32'h0000_003C, 4'b0001, 1, 32'hFFFF_FFC3};
    tbl[4]  = '{0, 4'b0000, 32'h0000_003C, 4'b0000, 0, 32'hFFFF_FFFF};
    tbl[5]  = '{0, 4'b0000, 32'h0000_0000, 4'b0000, 0, 32'hFFFF_FFFF};
    tbl[6]  = '{0, 4'b0010, 32'h0000_0000, 4'b0000, 1, 32'hFFFF_FFFF};
    tbl[7]  = '{0, 4'b0000, 32'h0000_0000, 4'b0000, 0, 32'hFFFF_FFFF};
    tbl[8]  = '{0, 4'b0000, 32'h0000_0000, 4'b0000, 0, 32'hFFFF_FFFF};
    tbl[9]  = '{0, 4'b0011, 32'h0000_77A5, 4'b0000, 1, 32'hFFFF_FFFF};
    tbl[10] = '{0, 4'b0011, 32'h0000_77A5, 4'b0000, 1, 32'hFFFF_FFFF};
    tbl[11] = '{0, 4'b0011, 32'h0000_77A5, 4'b0010, 1, 32'hFFFF_88FF};
    tbl[12] = '{0, 4'b0011, 32'h0000_1234, 4'b0010, 1, 32'hFFFF_EDFF};
    tbl[13] = '{1, 4'b1111, 32'h0000_0000, 4'b0000, 0, 32'hFFFF_FFFF};

    // Reset held with all agents requesting
    RST = 1'b1; REQ = 4'b1111; DIN = '1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("rst_en", EN, 0);
      check("rst_gnt", GNT, 0);
      check("rst_i", I, 32'hFFFF_FFFF);
      check("rst_busy", BUSY, 0);
    end
    RST = 1'b0;
    step();
    check("rst_after_en", EN, 0);
    check("rst_after_i", I, 32'hFFFF_FFFF);

    // Directed table
    do_reset();
    for (int v = 0; v < 14; v++) begin
      RST = tbl[v].rst; REQ = tbl[v].req; DIN = tbl[v].din;
      step();
      check($sformatf("tbl%0d_en", v), EN, tbl[v].en);
      check($sformatf("tbl%0d_busy", v), BUSY, tbl[v].busy);
      check($sformatf("tbl%0d_i", v), I, tbl[v].i);
    end
    RST = 1'b0;

    // Round-robin under full contention
    do_reset();
    q_own.delete(); q_high.delete(); q_gap.delete();
    REQ = 4'b1111; DIN = 32'h4433_2211;
    for (int c = 0; c < 40; c++) step();
    for (int k = 0; k < 5; k++) check($sformatf("rr_owner%0d", k), qget(q_own, k), k % N);
    for (int k = 0; k < 4; k++) check($sformatf("rr_high%0d", k), qget(q_high, k), MB);
    for (int k = 1; k < 5; k++) check($sformatf("rr_gap%0d", k), qget(q_gap, k), TURN + 1);

    // Lone holder keeps the bus past MAXBURST
    do_reset();
    REQ = 4'b0100; DIN = 32'h00C3_0000;
    hi_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (EN[2]) hi_cnt++;
    end
    check("lone_high_cycles", hi_cnt, 18);
    check("lone_i", I, 32'hFF3C_FFFF);
    REQ = '0;
    step();
    check("lone_release", EN, 0);

    // Abort during turnaround leaves ptr at 0
    do_reset();
    REQ = 4'b0010; step();
    check("abort_busy", BUSY, 1);
    REQ = 4'b0000; step();
    check("abort_idle", BUSY, 0);
    check("abort_en", EN, 0);
    step();
    REQ = 4'b1001;
    step(); step(); step();
    check("abort_ptr", EN, 4'b0001);

    // Reset in the middle of a drive
    do_reset();
    REQ = 4'b0001; DIN = 32'h0000_0011;
    step(); step(); step(); step();
    check("mid_driving", EN, 4'b0001);
    RST = 1'b1; step();
    check("mid_rst_en", EN, 0);
    check("mid_rst_i", I, 32'hFFFF_FFFF);
    check("mid_rst_busy", BUSY, 0);
    RST = 1'b0; REQ = 4'b1000;
    step(); step(); step();
    check("mid_owner3", EN, 4'b1000);

    // Random traffic
    do_reset();
    for (int c = 0; c < 800; c++) begin
      RST = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 3) == 0) REQ = N'($urandom);
      DIN = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
